// File: rtl/sbit_tap_loader_pkg.sv
// Shared constants and FSM encoding for the s-bit IDELAY tap loader.
package sbit_tap_loader_pkg;
    localparam int NCH_DEFAULT = 192;
    localparam int TAP_W       = 5;
    localparam int ADDR_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_READ,
        ST_STROBE,
        ST_SETTLE,
        ST_DONE
    } state_t;
endpackage

// File: rtl/sbit_tap_loader_if.sv
// Tap-table configuration bus: write port, readback port and write-refusal flag.
interface sbit_tap_loader_if;
    import sbit_tap_loader_pkg::*;

    logic              tap_wr_en;
    logic [ADDR_W-1:0] tap_wr_addr;
    logic [TAP_W-1:0]  tap_wr_data;
    logic [ADDR_W-1:0] tap_rd_addr;
    logic [TAP_W-1:0]  tap_rd_data;
    logic              wr_reject;

    modport master (
        output tap_wr_en, tap_wr_addr, tap_wr_data, tap_rd_addr,
        input  tap_rd_data, wr_reject
    );

    modport slave (
        input  tap_wr_en, tap_wr_addr, tap_wr_data, tap_rd_addr,
        output tap_rd_data, wr_reject
    );
endinterface

// File: rtl/tap_table_ram.sv
// NCH x TAP_W tap table: one write port, registered sequencer and readback read ports.
module tap_table_ram
    import sbit_tap_loader_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [TAP_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] seq_addr,
    output logic [TAP_W-1:0]  seq_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [TAP_W-1:0]  rb_data
);
    localparam logic [ADDR_W-1:0] NCH_A = ADDR_W'(NCH);

    logic [TAP_W-1:0] mem [NCH];

    // Out-of-range addresses read as zero; writes arrive pre-qualified.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) mem[i] <= '0;
            seq_data <= '0;
            rb_data  <= '0;
        end else begin
            if (wr_en && wr_addr < NCH_A) mem[wr_addr] <= wr_data;
            seq_data <= (seq_addr < NCH_A) ? mem[seq_addr] : '0;
            rb_data  <= (rb_addr  < NCH_A) ? mem[rb_addr]  : '0;
        end
    end
endmodule

// File: rtl/sbit_tap_loader.sv
// Sequences per-channel IDELAY tap loads from the tap table while holding the
// frame aligners in reset.
//
//   state    | meaning
//   IDLE     | table writable, waiting for start / auto start
//   WAIT_RDY | waiting for idelay_ready, bounded by RDY_TIMEOUT
//   READ     | table[ch] registered onto cntvalue
//   STROBE   | ld[ch] high for one cycle
//   SETTLE   | aligners held in reset after the last load
//   DONE     | one-cycle done pulse
module sbit_tap_loader
    import sbit_tap_loader_pkg::*;
#(
    parameter int NCH           = NCH_DEFAULT,
    parameter int SETTLE_CYCLES = 16,
    parameter int RDY_TIMEOUT   = 1024,
    parameter int AUTO_START    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 idelay_ready,
    input  logic                 start,
    sbit_tap_loader_if.slave     tap_bus,
    output logic [TAP_W-1:0]     cntvalue,
    output logic [NCH-1:0]       ld,
    output logic                 aligner_reset,
    output logic                 busy,
    output logic                 done,
    output logic                 rdy_timeout
);
    localparam int                TW      = 16;
    localparam logic [ADDR_W-1:0] LAST_CH = ADDR_W'(NCH - 1);
    localparam logic [ADDR_W-1:0] NCH_A   = ADDR_W'(NCH);

    state_t            state;
    logic [ADDR_W-1:0] ch;
    logic [TW-1:0]     timer;
    logic              auto_pend;
    logic [NCH-1:0]    ld_q;
    logic              wr_ok;
    logic [ADDR_W-1:0] seq_addr;
    logic [TAP_W-1:0]  seq_data;

    assign wr_ok = tap_bus.tap_wr_en && (state == ST_IDLE) && (tap_bus.tap_wr_addr < NCH_A);

    // Pre-fetch the next channel during STROBE so READ has its value ready.
    assign seq_addr = (state == ST_STROBE) ? ch + 1'b1 : ch;

    // A falling ready must kill the strobe in the same cycle it falls.
    assign ld = idelay_ready ? ld_q : '0;

    tap_table_ram #(.NCH(NCH)) u_table (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_ok),
        .wr_addr  (tap_bus.tap_wr_addr),
        .wr_data  (tap_bus.tap_wr_data),
        .seq_addr (seq_addr),
        .seq_data (seq_data),
        .rb_addr  (tap_bus.tap_rd_addr),
        .rb_data  (tap_bus.tap_rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= ST_IDLE;
            ch                <= '0;
            timer             <= '0;
            auto_pend         <= (AUTO_START != 0);
            cntvalue          <= '0;
            ld_q              <= '0;
            aligner_reset     <= 1'b1;
            busy              <= 1'b0;
            done              <= 1'b0;
            rdy_timeout       <= 1'b0;
            tap_bus.wr_reject <= 1'b0;
        end else begin
            done              <= 1'b0;
            ld_q              <= '0;
            tap_bus.wr_reject <= tap_bus.tap_wr_en && !wr_ok;
            case (state)
                ST_IDLE: begin
                    auto_pend     <= 1'b0;
                    aligner_reset <= 1'b0;
                    busy          <= 1'b0;
                    if (start || auto_pend) begin
                        if (start) rdy_timeout <= 1'b0;
                        state         <= ST_WAIT_RDY;
                        ch            <= '0;
                        timer         <= TW'(RDY_TIMEOUT - 1);
                        aligner_reset <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                ST_WAIT_RDY: begin
                    if (idelay_ready) begin
                        state <= ST_READ;
                    end else if (timer == '0) begin
                        rdy_timeout   <= 1'b1;
                        state         <= ST_IDLE;
                        busy          <= 1'b0;
                        aligner_reset <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_READ: begin
                    state    <= ST_STROBE;
                    cntvalue <= seq_data;
                    ld_q[ch] <= 1'b1;
                end
                ST_STROBE: begin
                    if (ch == LAST_CH) begin
                        state <= ST_SETTLE;
                        // Loaded one above SETTLE_CYCLES: done lands 2*NCH+SETTLE_CYCLES+3 after start.
                        timer <= TW'(SETTLE_CYCLES + 1);
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= ST_READ;
                    end
                end
                ST_SETTLE: begin
                    if (timer == '0) begin
                        state         <= ST_DONE;
                        done          <= 1'b1;
                        aligner_reset <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase

            if (!idelay_ready && (state == ST_READ || state == ST_STROBE || state == ST_SETTLE)) begin
                state         <= ST_WAIT_RDY;
                ch            <= '0;
                ld_q          <= '0;
                timer         <= TW'(RDY_TIMEOUT - 1);
                done          <= 1'b0;
                aligner_reset <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sbit_tap_loader.sv
// Directed bench for sbit_tap_loader: full loads, timeout, ready drop, write refusal, mid-load reset.
module tb_sbit_tap_loader;
    import sbit_tap_loader_pkg::*;

    localparam int N       = 192;
    localparam int DONE_AT = 2*N + 16 + 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             idelay_ready;
    logic             start;
    logic [TAP_W-1:0] cntvalue;
    logic [N-1:0]     ld;
    logic             aligner_reset;
    logic             busy;
    logic             done;
    logic             rdy_timeout;

    logic [TAP_W-1:0] model [N];
    int tests = 0;
    int fails = 0;
    int c, bad, nxt, dones, cv0, ldseen;

    sbit_tap_loader_if bus();

    sbit_tap_loader #(
        .NCH(N), .SETTLE_CYCLES(16), .RDY_TIMEOUT(1024), .AUTO_START(1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .idelay_ready  (idelay_ready),
        .start         (start),
        .tap_bus       (bus),
        .cntvalue      (cntvalue),
        .ld            (ld),
        .aligner_reset (aligner_reset),
        .busy          (busy),
        .done          (done),
        .rdy_timeout   (rdy_timeout)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ld_idx();
        if (ld === '0) return -1;
        if ($countones(ld) != 1) return -2;
        for (int i = 0; i < N; i++) if (ld[i] === 1'b1) return i;
        return -3;
    endfunction

    task automatic rd_check(input string tag, input int addr, input int exp);
        bus.tap_rd_addr = 8'(addr);
        tick();
        check(tag, 32'(bus.tap_rd_data), 32'(exp));
    endtask

    // Called in cycle 0 (the cycle after start was sampled); follows a clean load to IDLE.
    task automatic watch_load(input string tag);
        int cc = 0;
        int nbad = 0;
        int done_at = -1;
        int exp_i;
        while (busy === 1'b1 && cc < 600) begin
            exp_i = (cc >= 2 && cc <= 2*N && cc % 2 == 0) ? (cc - 2) / 2 : -1;
            if (ld_idx() != exp_i) nbad++;
            else if (exp_i >= 0 && cntvalue !== model[exp_i]) nbad++;
            if (aligner_reset !== (cc < DONE_AT)) nbad++;
            if (done === 1'b1) begin
                if (done_at < 0) done_at = cc;
                else nbad++;
            end
            tick();
            cc++;
        end
        check({tag, " ld/cntvalue/aligner errors"}, nbad, 0);
        check({tag, " done cycle"}, done_at, DONE_AT);
        check({tag, " idle cycle"}, cc, DONE_AT + 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        check({tag, " reached idle"}, busy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; idelay_ready = 1'b1;
        bus.tap_wr_en = 1'b0; bus.tap_wr_addr = '0; bus.tap_wr_data = '0; bus.tap_rd_addr = '0;
        for (int i = 0; i < N; i++) model[i] = '0;
        tick(); tick(); tick();

        check("reset busy", busy, 1'b0);
        check("reset aligner_reset", aligner_reset, 1'b1);
        check("reset ld", ld_idx(), -1);
        check("reset cntvalue", cntvalue, 0);
        check("reset done/rdy_timeout/wr_reject", {done, rdy_timeout, bus.wr_reject}, 3'b000);
        check("reset tap_rd_data", bus.tap_rd_data, 0);

        // Auto start on reset release with an all-zero table
        reset = 1'b0;
        tick();
        check("auto start busy", busy, 1'b1);
        watch_load("auto");

        // Program table[i] = i mod 32
        bad = 0;
        for (int i = 0; i < N; i++) begin
            bus.tap_wr_en = 1'b1; bus.tap_wr_addr = 8'(i); bus.tap_wr_data = 5'(i % 32);
            model[i] = 5'(i % 32);
            tick();
            if (bus.wr_reject !== 1'b0) bad++;
        end
        bus.tap_wr_en = 1'b0;
        check("idle writes not rejected", bad, 0);
        rd_check("readback 37", 37, 5);
        rd_check("readback 191", 191, 31);

        start = 1'b1; tick(); start = 1'b0;
        watch_load("pattern");

        // Write while busy is refused
        start = 1'b1; tick(); start = 1'b0;
        bus.tap_wr_en = 1'b1; bus.tap_wr_addr = 8'd3; bus.tap_wr_data = 5'd17;
        tick();
        bus.tap_wr_en = 1'b0;
        check("busy write wr_reject", bus.wr_reject, 1'b1);
        tick();
        check("wr_reject is a pulse", bus.wr_reject, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        check("start while busy ignored", busy, 1'b1);
        wait_idle("busy write");
        rd_check("table[3] unchanged", 3, 3);

        // Out-of-range address in IDLE is refused
        bus.tap_wr_en = 1'b1; bus.tap_wr_addr = 8'd200; bus.tap_wr_data = 5'd7;
        tick();
        bus.tap_wr_en = 1'b0;
        check("addr 200 wr_reject", bus.wr_reject, 1'b1);
        rd_check("table[8] unchanged", 8, 8);
        rd_check("table[72] unchanged", 72, 8);

        bus.tap_wr_en = 1'b1; bus.tap_wr_addr = 8'd3; bus.tap_wr_data = 5'd17;
        model[3] = 5'd17;
        tick();
        bus.tap_wr_en = 1'b0;
        check("valid idle write no reject", bus.wr_reject, 1'b0);
        rd_check("table[3] written", 3, 17);

        // idelay_ready never arrives
        idelay_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        ldseen = 0;
        for (int k = 0; k < 1023; k++) begin
            if (ld !== '0) ldseen++;
            tick();
        end
        check("timeout last wait cycle busy", {busy, rdy_timeout}, 2'b10);
        tick();
        check("timeout busy", busy, 1'b0);
        check("timeout rdy_timeout", rdy_timeout, 1'b1);
        check("timeout aligner_reset", aligner_reset, 1'b0);
        check("timeout no ld", ldseen, 0);
        tick(); tick();
        check("rdy_timeout sticky", rdy_timeout, 1'b1);

        idelay_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        check("start clears rdy_timeout", rdy_timeout, 1'b0);
        watch_load("after timeout");

        // Write with start in the same cycle, then ready drops at channel 100
        start = 1'b1;
        bus.tap_wr_en = 1'b1; bus.tap_wr_addr = 8'd0; bus.tap_wr_data = 5'd9;
        model[0] = 5'd9;
        tick();
        start = 1'b0; bus.tap_wr_en = 1'b0;
        c = 0; cv0 = -1; dones = 0;
        while (ld_idx() != 100 && c < 400) begin
            if (ld_idx() == 0) cv0 = int'(cntvalue);
            if (done === 1'b1) dones++;
            tick();
            c++;
        end
        check("drop reached ch100", ld_idx(), 100);
        check("write+start cntvalue ch0", cv0, 9);
        idelay_ready = 1'b0;
        #1;
        check("drop cycle ld", ld_idx(), -1);
        tick();
        check("drop -> wait busy/aligner", {busy, aligner_reset}, 2'b11);
        bad = 0;
        for (int k = 0; k < 9; k++) begin
            if (ld !== '0) bad++;
            if (done === 1'b1) dones++;
            tick();
        end
        idelay_ready = 1'b1;
        nxt = 0; c = 0;
        while (busy === 1'b1 && c < 700) begin
            if (ld_idx() >= 0) begin
                if (ld_idx() != nxt || cntvalue !== model[nxt]) bad++;
                nxt++;
            end else if (ld_idx() != -1) bad++;
            if (done === 1'b1) dones++;
            tick();
            c++;
        end
        check("reload ld order/cntvalue errors", bad, 0);
        check("reload channel count", nxt, N);
        check("single done after drop", dones, 1);

        // Reset mid-load at channel 50
        start = 1'b1; tick(); start = 1'b0;
        c = 0;
        while (ld_idx() != 50 && c < 400) begin
            tick();
            c++;
        end
        check("reached ch50", ld_idx(), 50);
        reset = 1'b1;
        tick();
        check("mid reset ld", ld_idx(), -1);
        check("mid reset busy/aligner/done", {busy, aligner_reset, done}, 3'b010);
        reset = 1'b0;
        for (int i = 0; i < N; i++) model[i] = '0;
        tick();
        check("post reset auto start", busy, 1'b1);
        watch_load("post reset");
        rd_check("post reset table[37]", 37, 0);
        rd_check("post reset table[3]", 3, 0);
        rd_check("post reset table[191]", 191, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sbit_tap_loader.md
SBIT_TAP_LOADER -- requirements
Module: sbit_tap_loader

Interface
REQ-001 Parameter NCH, default 192: number of s-bit input channels; one IDELAY per channel.
REQ-002 Parameter SETTLE_CYCLES, default 16: cycles aligner_reset is held after the last tap load.
REQ-003 Parameter RDY_TIMEOUT, default 1024: maximum cycles to wait for idelay_ready.
REQ-004 Parameter AUTO_START, default 1: when 1, a load sequence is requested automatically on reset release.
REQ-005 clock  in  1  single clock domain for the whole block.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 idelay_ready  in  1  IDELAYCTRL calibrated flag.
REQ-008 start  in  1  single-cycle load request.
REQ-009 tap_wr_en  in  1  write strobe for the tap table.
REQ-010 tap_wr_addr  in  8  channel index for a write.
REQ-011 tap_wr_data  in  5  tap value for a write.
REQ-012 tap_rd_addr  in  8  readback channel index.
REQ-013 tap_rd_data  out  5  registered readback of table[tap_rd_addr], 1-cycle latency.
REQ-014 cntvalue  out  5  shared IDELAY CNTVALUEIN bus.
REQ-015 ld  out  NCH  one-hot IDELAY LD strobes.
REQ-016 aligner_reset  out  1  held high while taps are changing; drives the frame aligners' reset.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  one-cycle pulse on sequence completion.
REQ-019 rdy_timeout  out  1  sticky; set on an idelay_ready timeout.
REQ-020 wr_reject  out  1  one-cycle pulse when a write is refused.

Function
REQ-021 FSM states: IDLE, WAIT_RDY, READ, STROBE, SETTLE, DONE.
REQ-022 IDLE -> WAIT_RDY on start, or on the first cycle after reset when AUTO_START=1; channel counter cleared to 0.
REQ-023 WAIT_RDY -> READ when idelay_ready=1; on RDY_TIMEOUT cycles without ready, set rdy_timeout and go to IDLE.
REQ-024 READ: table[ch] is registered onto cntvalue; ld is all-zero.
REQ-025 STROBE: ld[ch]=1 for exactly one cycle while cntvalue is held; next state is READ with ch+1, or SETTLE after ch=NCH-1.
REQ-026 Each channel takes 2 cycles, so a full load is 2*NCH cycles from the first READ to the end of the last STROBE.
REQ-027 SETTLE: count SETTLE_CYCLES, then go to DONE.
REQ-028 DONE: done=1 for one cycle, then go to IDLE.
REQ-029 aligner_reset=1 in WAIT_RDY, READ, STROBE and SETTLE; 0 in IDLE and DONE.
REQ-030 At most one ld bit is high in any cycle.
REQ-031 idelay_ready falling during READ, STROBE or SETTLE: ld is forced to 0 that cycle, ch resets to 0, and the FSM goes to WAIT_RDY; no done pulse is produced.
REQ-032 start while busy is ignored.
REQ-033 Table writes are accepted only in IDLE.
REQ-034 A write attempted in any other state is dropped and produces a wr_reject pulse.
REQ-035 tap_wr_addr >= NCH is dropped and produces a wr_reject pulse.
REQ-036 rdy_timeout clears only on reset or on the next start.
REQ-037 Writes and start in the same IDLE cycle: the write is applied first, so the new value is used for the load.

Reset
REQ-038 On reset: FSM returns to IDLE, ch=0, all table entries=0, cntvalue=0, ld=0, aligner_reset=1, busy=0, done=0, rdy_timeout=0, wr_reject=0, tap_rd_data=0.
REQ-039 Reset asserted mid-sequence aborts the sequence immediately; the next cycle satisfies REQ-038.
REQ-040 When AUTO_START=0, aligner_reset drops to 0 one cycle after reset release.

Structure
REQ-041 A shared package holds the FSM state encoding, NCH, and the tap width (5).
REQ-042 The tap table is one sub-module, tap_table_ram: NCH x 5, with one write port and two registered read ports (sequencer and readback).

Verification
REQ-043 Stimulus: write table[i]=i mod 32 for all i, then pulse start with idelay_ready=1. Required: ld[i] pulses at cycle 2i+2 after start with cntvalue=i mod 32, done arrives 2*192+16+3 cycles after start, and aligner_reset falls with done.
REQ-044 Stimulus: start with idelay_ready=0 for 1024 cycles. Required: rdy_timeout=1, busy=0, no ld pulse.
REQ-045 Stimulus: drop idelay_ready during channel 100's STROBE, restore it 10 cycles later. Required: no ld in the drop cycle, reload restarts at ld[0], a single done pulse at the end.
REQ-046 Stimulus: tap_wr_en while busy, and separately tap_wr_addr=200 in IDLE. Required: wr_reject pulses each time and the table is unchanged on readback.
REQ-047 Stimulus: reset asserted at channel 50. Required: next cycle ld=0, busy=0, the table reads back all zeros, and with AUTO_START=1 a new sequence starts from channel 0.
